// File: rtl/dmem_write_arbiter.sv
// Per-core store FIFOs drained round-robin into the single registered dmem write port.
// Optional DMEM_WARB_CUTTHROUGH_EN: a lone store into an all-empty arbiter skips its FIFO.

module dmem_warb_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          w_push_ok, w_pop_ok;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_rdata   = r_mem[r_rptr];
  assign o_ovf     = r_ovf;
  assign w_pop_ok  = i_pop && !o_empty;
  // A full FIFO still takes a store when its head leaves at the same edge.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (i_push && !w_push_ok) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end
endmodule

module dmem_write_arbiter #(
  parameter int NCORES = 8,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int DEPTH  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NCORES-1:0]    i_core_we,
  input  logic [NCORES*AW-1:0] i_core_addr,
  input  logic [NCORES*DW-1:0] i_core_wd,
  output logic                 o_mem_we,
  output logic [AW-1:0]        o_mem_addr,
  output logic [DW-1:0]        o_mem_wd,
  output logic [2:0]           o_mem_src,
  output logic [NCORES-1:0]    o_fifo_full,
  output logic [NCORES-1:0]    o_ovf_sticky,
  output logic                 o_idle
);
  localparam int LGW = $clog2(NCORES);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t [NCORES-1:0] w_in, w_head;
  logic [NCORES-1:0]   w_push, w_pop, w_empty;
  logic                w_gnt_vld;
  logic [LGW-1:0]      w_gnt_idx;
  int                  w_idx;

  logic                r_mem_we;
  logic [AW-1:0]       r_mem_addr;
  logic [DW-1:0]       r_mem_wd;
  logic [2:0]          r_mem_src;
  logic [LGW-1:0]      r_last_grant;

  genvar g;
  generate
    for (g = 0; g < NCORES; g++) begin : g_lane
      assign w_in[g]  = {i_core_addr[g*AW +: AW], i_core_wd[g*DW +: DW]};
      assign w_pop[g] = w_gnt_vld && (w_gnt_idx == LGW'(g));
      dmem_warb_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push[g]),
        .i_pop   (w_pop[g]),
        .i_wdata (w_in[g]),
        .o_rdata (w_head[g]),
        .o_empty (w_empty[g]),
        .o_full  (o_fifo_full[g]),
        .o_ovf   (o_ovf_sticky[g])
      );
    end
  endgenerate

  // Walk from farthest to nearest so the first non-empty after last_grant wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    for (int k = NCORES; k >= 1; k--) begin
      w_idx = int'(r_last_grant) + k;
      if (w_idx >= NCORES) w_idx = w_idx - NCORES;
      if (!w_empty[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = LGW'(w_idx);
      end
    end
  end

`ifdef DMEM_WARB_CUTTHROUGH_EN
  logic           w_cut;
  logic [LGW-1:0] w_cut_idx;

  // All-empty implies no pop this edge, so a single store may bypass its FIFO.
  always_comb begin
    w_cut     = (&w_empty) && $onehot(i_core_we);
    w_cut_idx = '0;
    for (int i = 0; i < NCORES; i++)
      if (i_core_we[i]) w_cut_idx = LGW'(i);
  end
  assign w_push = i_core_we & ~{NCORES{w_cut}};
`else
  assign w_push = i_core_we;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wd     <= '0;
      r_mem_src    <= '0;
      r_last_grant <= LGW'(NCORES - 1);
    end else begin
      r_mem_we <= 1'b0;
`ifdef DMEM_WARB_CUTTHROUGH_EN
      if (w_cut) begin
        r_mem_we     <= 1'b1;
        r_mem_addr   <= w_in[w_cut_idx].addr;
        r_mem_wd     <= w_in[w_cut_idx].data;
        r_mem_src    <= 3'(w_cut_idx);
        r_last_grant <= w_cut_idx;
      end else
`endif
      if (w_gnt_vld) begin
        r_mem_we     <= 1'b1;
        r_mem_addr   <= w_head[w_gnt_idx].addr;
        r_mem_wd     <= w_head[w_gnt_idx].data;
        r_mem_src    <= 3'(w_gnt_idx);
        r_last_grant <= w_gnt_idx;
      end
    end
  end

  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_wd   = r_mem_wd;
  assign o_mem_src  = r_mem_src;
  assign o_idle     = (&w_empty) && !r_mem_we;
endmodule
